// File: rtl/komandara_axi_pkg.sv
// Shared AXI4-Lite types for the komandara bus masters.
package komandara_axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi_resp_e;

  typedef struct packed {
    logic aw_pend;
    logic w_pend;
    logic ar_pend;
  } req_flags_t;

endpackage

// File: rtl/komandara_skid_buffer.sv
// Two-entry skid buffer; s_ready depends only on registered occupancy.
module komandara_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o
);

  logic [WIDTH-1:0] buf_q [2];
  logic             wr_q, rd_q;
  logic [1:0]       cnt_q;
  logic             push, pop;

  assign s_ready_o = (cnt_q != 2'd2);
  assign m_valid_o = (cnt_q != 2'd0);
  assign m_data_o  = buf_q[rd_q];
  assign push      = s_valid_i && s_ready_o;
  assign pop       = m_valid_o && m_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_q] <= s_data_i;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      if (push && !pop)      cnt_q <= cnt_q + 2'd1;
      else if (pop && !push) cnt_q <= cnt_q - 2'd1;
    end
  end

endmodule

// File: rtl/komandara_sync_fifo.sv
// Synchronous FIFO with arbitrary (non-power-of-two) depth and occupancy count.
module komandara_sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/komandara_axi4lite_master_ooo.sv
// Multi-outstanding AXI4-Lite master, responses returned in command order.
// Define KOMANDARA_AXI_MST_SVA_EN to compile in the protocol assertions.
module komandara_axi4lite_master_ooo
  import komandara_axi_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int STRB_WIDTH     = DATA_WIDTH / 8,
  localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb_i,
  input  logic [2:0]            cmd_prot_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [1:0]            rsp_resp_o,
  output logic                  rsp_write_o,
  output logic [CNT_WIDTH-1:0]  outstanding_o,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr_o,
  output logic [2:0]            m_axi_awprot_o,
  output logic                  m_axi_awvalid_o,
  input  logic                  m_axi_awready_i,
  output logic [DATA_WIDTH-1:0] m_axi_wdata_o,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb_o,
  output logic                  m_axi_wvalid_o,
  input  logic                  m_axi_wready_i,
  input  logic [1:0]            m_axi_bresp_i,
  input  logic                  m_axi_bvalid_i,
  output logic                  m_axi_bready_o,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr_o,
  output logic [2:0]            m_axi_arprot_o,
  output logic                  m_axi_arvalid_o,
  input  logic                  m_axi_arready_i,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata_i,
  input  logic [1:0]            m_axi_rresp_i,
  input  logic                  m_axi_rvalid_i,
  output logic                  m_axi_rready_o
);

  req_flags_t            flags_q, flags_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [2:0]            prot_q;
  logic                  init_q;
  logic                  stage_idle, stage_completing, cmd_fire;
  logic                  fifo_full, fifo_empty, head_is_write;
  logic [CNT_WIDTH-1:0]  fifo_cnt;
  logic                  b_valid, r_valid, rsp_fire;
  logic [1:0]            b_resp;
  logic [DATA_WIDTH+1:0] r_beat;

  // ---------------- request stage ----------------
  assign stage_idle       = !(flags_q.aw_pend || flags_q.w_pend || flags_q.ar_pend);
  assign stage_completing = (!flags_q.aw_pend || m_axi_awready_i) &&
                            (!flags_q.w_pend  || m_axi_wready_i)  &&
                            (!flags_q.ar_pend || m_axi_arready_i);

  // init_q holds cmd_ready low through reset and releases it one edge later;
  // !fifo_full is count < MAX_OUTSTANDING, so a same-cycle pop never helps.
  assign cmd_ready_o = init_q && !fifo_full && (stage_idle || stage_completing);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;

  always_comb begin
    flags_d = flags_q;
    if (m_axi_awready_i) flags_d.aw_pend = 1'b0;
    if (m_axi_wready_i)  flags_d.w_pend  = 1'b0;
    if (m_axi_arready_i) flags_d.ar_pend = 1'b0;
    if (cmd_fire) begin
      flags_d.aw_pend = cmd_write_i;
      flags_d.w_pend  = cmd_write_i;
      flags_d.ar_pend = !cmd_write_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flags_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      init_q  <= 1'b0;
    end else begin
      flags_q <= flags_d;
      init_q  <= 1'b1;
      if (cmd_fire) begin
        addr_q  <= cmd_addr_i;
        wdata_q <= cmd_wdata_i;
        strb_q  <= cmd_wstrb_i;
        prot_q  <= cmd_prot_i;
      end
    end
  end

  assign m_axi_awvalid_o = flags_q.aw_pend;
  assign m_axi_wvalid_o  = flags_q.w_pend;
  assign m_axi_arvalid_o = flags_q.ar_pend;
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_awprot_o  = prot_q;
  assign m_axi_arprot_o  = prot_q;
  assign m_axi_wdata_o   = wdata_q;
  assign m_axi_wstrb_o   = strb_q;

  // ---------------- ordering and response merge ----------------
  komandara_sync_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cmd_fire),
    .wdata_i (cmd_write_i),
    .pop_i   (rsp_fire),
    .rdata_o (head_is_write),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  komandara_skid_buffer #(
    .WIDTH (2)
  ) u_b_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_valid_i (m_axi_bvalid_i),
    .s_ready_o (m_axi_bready_o),
    .s_data_i  (m_axi_bresp_i),
    .m_valid_o (b_valid),
    .m_ready_i (rsp_ready_i && !fifo_empty && head_is_write),
    .m_data_o  (b_resp)
  );

  komandara_skid_buffer #(
    .WIDTH (DATA_WIDTH + 2)
  ) u_r_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_valid_i (m_axi_rvalid_i),
    .s_ready_o (m_axi_rready_o),
    .s_data_i  ({m_axi_rresp_i, m_axi_rdata_i}),
    .m_valid_o (r_valid),
    .m_ready_i (rsp_ready_i && !fifo_empty && !head_is_write),
    .m_data_o  (r_beat)
  );

  assign rsp_valid_o   = !fifo_empty && (head_is_write ? b_valid : r_valid);
  assign rsp_fire      = rsp_valid_o && rsp_ready_i;
  assign rsp_write_o   = head_is_write;
  assign rsp_rdata_o   = head_is_write ? '0 : r_beat[DATA_WIDTH-1:0];
  assign rsp_resp_o    = head_is_write ? b_resp : r_beat[DATA_WIDTH+1:DATA_WIDTH];
  assign outstanding_o = fifo_cnt;

`ifdef KOMANDARA_AXI_MST_SVA_EN
  // Per-type counts of accepted commands still waiting for their B/R beat.
  logic [CNT_WIDTH-1:0] sva_wr_q, sva_rd_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sva_wr_q <= '0;
      sva_rd_q <= '0;
    end else begin
      sva_wr_q <= sva_wr_q + CNT_WIDTH'(cmd_fire && cmd_write_i)
                           - CNT_WIDTH'(m_axi_bvalid_i && m_axi_bready_o);
      sva_rd_q <= sva_rd_q + CNT_WIDTH'(cmd_fire && !cmd_write_i)
                           - CNT_WIDTH'(m_axi_rvalid_i && m_axi_rready_o);
    end
  end

  a_aw_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    m_axi_awvalid_o && !m_axi_awready_i |=>
      m_axi_awvalid_o && $stable(m_axi_awaddr_o) && $stable(m_axi_awprot_o));
  a_w_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    m_axi_wvalid_o && !m_axi_wready_i |=>
      m_axi_wvalid_o && $stable(m_axi_wdata_o) && $stable(m_axi_wstrb_o));
  a_ar_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    m_axi_arvalid_o && !m_axi_arready_i |=>
      m_axi_arvalid_o && $stable(m_axi_araddr_o) && $stable(m_axi_arprot_o));
  a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_cnt <= CNT_WIDTH'(MAX_OUTSTANDING));
  a_no_spurious_b: assert property (@(posedge clk_i) disable iff (rst_i)
    m_axi_bvalid_i |-> sva_wr_q != '0);
  a_no_spurious_r: assert property (@(posedge clk_i) disable iff (rst_i)
    m_axi_rvalid_i |-> sva_rd_q != '0);
  a_rsp_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_valid_o && !rsp_ready_i |=>
      rsp_valid_o && $stable(rsp_rdata_o) && $stable(rsp_resp_o) && $stable(rsp_write_o));
`endif

endmodule
